// File: rtl/multicycle_controller_if.sv
// Control bundle between the multicycle MIPS controller and its datapath.
// The master modport is the controller; the slave modport is the datapath/memory side.
interface multicycle_controller_if #(
    parameter int CNT_W = 32
);
    logic [5:0]       op;
    logic             mem_ready;
    logic             mem_req;
    logic             i_or_d;
    logic             mem_write;
    logic             ir_write;
    logic             pc_write;
    logic             branch;
    logic [1:0]       pc_src;
    logic             alu_src_a;
    logic [1:0]       alu_src_b;
    logic [1:0]       alu_op;
    logic             reg_dst;
    logic             mem_to_reg;
    logic             reg_write;
    logic             instr_done;
    logic             illegal_op;
    logic [CNT_W-1:0] retire_count;
    logic [3:0]       state;

    modport master (
        input  op, mem_ready,
        output mem_req, i_or_d, mem_write, ir_write, pc_write, branch, pc_src,
               alu_src_a, alu_src_b, alu_op, reg_dst, mem_to_reg, reg_write,
               instr_done, illegal_op, retire_count, state
    );

    modport slave (
        output op, mem_ready,
        input  mem_req, i_or_d, mem_write, ir_write, pc_write, branch, pc_src,
               alu_src_a, alu_src_b, alu_op, reg_dst, mem_to_reg, reg_write,
               instr_done, illegal_op, retire_count, state
    );
endinterface

// File: rtl/multicycle_controller.sv
// Moore controller sequencing a multicycle MIPS datapath (R-type, lw, sw, beq, addi, j)
// with a request/ready memory handshake and a retired-instruction counter.
//
// state       | meaning
// RESET   (0) | idle after reset, all outputs low
// FETCH   (1) | read instruction at PC, PC+4; waits for mem_ready
// DECODE  (2) | decode opcode, precompute branch target
// MEMADR  (3) | compute load/store address
// MEMRD   (4) | data read; waits for mem_ready
// MEMWB   (5) | write loaded data to rt
// MEMWR   (6) | data write; waits for mem_ready
// EXECUTE (7) | R-type ALU operation
// ALUWB   (8) | write ALU result to rd
// BRANCH  (9) | compare and conditionally take branch
// ADDIEX (10) | A + immediate
// ADDIWB (11) | write addi result to rt
// JUMP   (12) | load jump target into PC
module multicycle_controller #(
    parameter int CNT_W = 32
) (
    input  logic                    clk,
    input  logic                    rst_n,
    multicycle_controller_if.master bus
);

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;

    typedef enum logic [3:0] {
        S_RESET   = 4'd0,
        S_FETCH   = 4'd1,
        S_DECODE  = 4'd2,
        S_MEMADR  = 4'd3,
        S_MEMRD   = 4'd4,
        S_MEMWB   = 4'd5,
        S_MEMWR   = 4'd6,
        S_EXECUTE = 4'd7,
        S_ALUWB   = 4'd8,
        S_BRANCH  = 4'd9,
        S_ADDIEX  = 4'd10,
        S_ADDIWB  = 4'd11,
        S_JUMP    = 4'd12
    } state_t;

    state_t           st;
    logic [CNT_W-1:0] cnt;
    logic             done;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            st  <= S_RESET;
            cnt <= '0;
        end else begin
            if (done)
                cnt <= cnt + CNT_W'(1);
            case (st)
                S_RESET:   st <= S_FETCH;
                S_FETCH:   if (bus.mem_ready) st <= S_DECODE;
                S_DECODE: begin
                    case (bus.op)
                        OP_LW, OP_SW: st <= S_MEMADR;
                        OP_RTYPE:     st <= S_EXECUTE;
                        OP_BEQ:       st <= S_BRANCH;
                        OP_ADDI:      st <= S_ADDIEX;
                        OP_J:         st <= S_JUMP;
                        default:      st <= S_FETCH;
                    endcase
                end
                // IR is stable for the whole instruction, so op still identifies lw vs sw here
                S_MEMADR:  st <= (bus.op == OP_LW) ? S_MEMRD : S_MEMWR;
                S_MEMRD:   if (bus.mem_ready) st <= S_MEMWB;
                S_MEMWB:   st <= S_FETCH;
                S_MEMWR:   if (bus.mem_ready) st <= S_FETCH;
                S_EXECUTE: st <= S_ALUWB;
                S_ALUWB:   st <= S_FETCH;
                S_BRANCH:  st <= S_FETCH;
                S_ADDIEX:  st <= S_ADDIWB;
                S_ADDIWB:  st <= S_FETCH;
                S_JUMP:    st <= S_FETCH;
                default:   st <= S_FETCH;
            endcase
        end
    end

    always_comb begin
        bus.mem_req    = 1'b0;
        bus.i_or_d     = 1'b0;
        bus.mem_write  = 1'b0;
        bus.ir_write   = 1'b0;
        bus.pc_write   = 1'b0;
        bus.branch     = 1'b0;
        bus.pc_src     = 2'b00;
        bus.alu_src_a  = 1'b0;
        bus.alu_src_b  = 2'b00;
        bus.alu_op     = 2'b00;
        bus.reg_dst    = 1'b0;
        bus.mem_to_reg = 1'b0;
        bus.reg_write  = 1'b0;
        done           = 1'b0;
        bus.illegal_op = 1'b0;
        case (st)
            S_FETCH: begin
                bus.mem_req   = 1'b1;
                bus.alu_src_b = 2'b01;
                bus.ir_write  = bus.mem_ready;
                bus.pc_write  = bus.mem_ready;
            end
            S_DECODE: begin
                bus.alu_src_b  = 2'b11;
                bus.illegal_op = !(bus.op inside {OP_LW, OP_SW, OP_RTYPE, OP_BEQ, OP_ADDI, OP_J});
            end
            S_MEMADR: begin
                bus.alu_src_a = 1'b1;
                bus.alu_src_b = 2'b10;
            end
            S_MEMRD: begin
                bus.mem_req = 1'b1;
                bus.i_or_d  = 1'b1;
            end
            S_MEMWB: begin
                bus.reg_write  = 1'b1;
                bus.mem_to_reg = 1'b1;
                done           = 1'b1;
            end
            S_MEMWR: begin
                bus.mem_req   = 1'b1;
                bus.i_or_d    = 1'b1;
                bus.mem_write = 1'b1;
                done          = bus.mem_ready;
            end
            S_EXECUTE: begin
                bus.alu_src_a = 1'b1;
                bus.alu_op    = 2'b10;
            end
            S_ALUWB: begin
                bus.reg_write = 1'b1;
                bus.reg_dst   = 1'b1;
                done          = 1'b1;
            end
            S_BRANCH: begin
                bus.alu_src_a = 1'b1;
                bus.alu_op    = 2'b01;
                bus.pc_src    = 2'b01;
                bus.branch    = 1'b1;
                done          = 1'b1;
            end
            S_ADDIEX: begin
                bus.alu_src_a = 1'b1;
                bus.alu_src_b = 2'b10;
            end
            S_ADDIWB: begin
                bus.reg_write = 1'b1;
                done          = 1'b1;
            end
            S_JUMP: begin
                bus.pc_src   = 2'b10;
                bus.pc_write = 1'b1;
                done         = 1'b1;
            end
            default: ;
        endcase
    end

    assign bus.instr_done   = done;
    assign bus.retire_count = cnt;
    assign bus.state        = st;

endmodule

// File: tb/tb_multicycle_controller.sv
// Bench for multicycle_controller: per-cycle expected state/outputs queued per instruction,
// popped and compared each cycle, with a model of the retired-instruction count.
module tb_multicycle_controller;
    localparam int CNT_W = 32;

    localparam logic [5:0] LW = 6'b100011, SW = 6'b101011, RT = 6'b000000;
    localparam logic [5:0] BEQ = 6'b000100, ADDI = 6'b001000, JMP = 6'b000010;
    localparam logic [3:0] T_RESET = 0, T_FETCH = 1, T_DECODE = 2, T_MEMADR = 3, T_MEMRD = 4,
                           T_MEMWB = 5, T_MEMWR = 6, T_EXEC = 7, T_ALUWB = 8, T_BRANCH = 9,
                           T_ADDIEX = 10, T_ADDIWB = 11, T_JUMP = 12;

    logic clk = 1'b0;
    logic rst_n = 1'b0;

    multicycle_controller_if #(.CNT_W(CNT_W)) bus ();
    multicycle_controller #(.CNT_W(CNT_W)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

    always #5 clk = ~clk;

    typedef struct packed {
        logic [5:0] op;
        logic       rdy;
        logic [3:0] st;
    } ent_t;

    ent_t             exp_q[$];
    int               checks = 0;
    int               failures = 0;
    logic [CNT_W-1:0] exp_cnt = '0;

    logic [17:0] obs;
    assign obs = {bus.mem_req, bus.i_or_d, bus.mem_write, bus.ir_write, bus.pc_write,
                  bus.branch, bus.pc_src, bus.alu_src_a, bus.alu_src_b, bus.alu_op,
                  bus.reg_dst, bus.mem_to_reg, bus.reg_write, bus.instr_done, bus.illegal_op};

    // Expected control word from the state table; bit 1 is instr_done
    function automatic logic [17:0] exp_outs(input logic [3:0] st, input logic rdy,
                                             input logic [5:0] op);
        logic mr, iod, mw, irw, pcw, br, a, rd, m2r, rw, dn, ill;
        logic [1:0] psrc, b, aop;
        {mr, iod, mw, irw, pcw, br, a, rd, m2r, rw, dn, ill} = '0;
        psrc = 2'b00; b = 2'b00; aop = 2'b00;
        case (st)
            T_FETCH:  begin mr = 1; b = 2'b01; irw = rdy; pcw = rdy; end
            T_DECODE: begin b = 2'b11; ill = !(op inside {LW, SW, RT, BEQ, ADDI, JMP}); end
            T_MEMADR: begin a = 1; b = 2'b10; end
            T_MEMRD:  begin mr = 1; iod = 1; end
            T_MEMWB:  begin rw = 1; m2r = 1; dn = 1; end
            T_MEMWR:  begin mr = 1; iod = 1; mw = 1; dn = rdy; end
            T_EXEC:   begin a = 1; aop = 2'b10; end
            T_ALUWB:  begin rw = 1; rd = 1; dn = 1; end
            T_BRANCH: begin a = 1; aop = 2'b01; psrc = 2'b01; br = 1; dn = 1; end
            T_ADDIEX: begin a = 1; b = 2'b10; end
            T_ADDIWB: begin rw = 1; dn = 1; end
            T_JUMP:   begin psrc = 2'b10; pcw = 1; dn = 1; end
            default: ;
        endcase
        return {mr, iod, mw, irw, pcw, br, psrc, a, b, aop, rd, m2r, rw, dn, ill};
    endfunction

    task automatic push(input logic [5:0] op, input logic rdy, input logic [3:0] st);
        ent_t e;
        e.op = op; e.rdy = rdy; e.st = st;
        exp_q.push_back(e);
    endtask

    // mem_ready is randomised in states that must ignore it
    task automatic push_instr(input logic [5:0] op, input int wait_fetch, input int wait_mem);
        for (int i = 0; i < wait_fetch; i++) push(op, 1'b0, T_FETCH);
        push(op, 1'b1, T_FETCH);
        push(op, 1'($urandom_range(0, 1)), T_DECODE);
        case (op)
            LW: begin
                push(op, 1'($urandom_range(0, 1)), T_MEMADR);
                for (int i = 0; i < wait_mem; i++) push(op, 1'b0, T_MEMRD);
                push(op, 1'b1, T_MEMRD);
                push(op, 1'($urandom_range(0, 1)), T_MEMWB);
            end
            SW: begin
                push(op, 1'($urandom_range(0, 1)), T_MEMADR);
                for (int i = 0; i < wait_mem; i++) push(op, 1'b0, T_MEMWR);
                push(op, 1'b1, T_MEMWR);
            end
            RT: begin
                push(op, 1'($urandom_range(0, 1)), T_EXEC);
                push(op, 1'($urandom_range(0, 1)), T_ALUWB);
            end
            ADDI: begin
                push(op, 1'($urandom_range(0, 1)), T_ADDIEX);
                push(op, 1'($urandom_range(0, 1)), T_ADDIWB);
            end
            BEQ: push(op, 1'($urandom_range(0, 1)), T_BRANCH);
            JMP: push(op, 1'($urandom_range(0, 1)), T_JUMP);
            default: ;
        endcase
    endtask

    // Pops n entries (all when n < 0); entered and left just after a rising edge
    task automatic drain(input string name, input int n);
        ent_t        e;
        logic [17:0] eo;
        int          k = 0;
        while (exp_q.size() > 0 && (n < 0 || k < n)) begin
            e = exp_q.pop_front();
            bus.op = e.op;
            bus.mem_ready = e.rdy;
            @(negedge clk);
            eo = exp_outs(e.st, e.rdy, e.op);
            checks++;
            if (bus.state !== e.st) begin
                failures++;
                $display("FAIL %s cyc%0d state got=%0d exp=%0d", name, k, bus.state, e.st);
            end
            checks++;
            if (obs !== eo) begin
                failures++;
                $display("FAIL %s cyc%0d outs got=%b exp=%b (state %0d)", name, k, obs, eo, e.st);
            end
            checks++;
            if (bus.retire_count !== exp_cnt) begin
                failures++;
                $display("FAIL %s cyc%0d retire_count got=%0d exp=%0d", name, k,
                         bus.retire_count, exp_cnt);
            end
            if (eo[1]) exp_cnt = exp_cnt + 1'b1;
            @(posedge clk);
            #1;
            k++;
        end
    endtask

    task automatic check_after(input string name, input logic [CNT_W-1:0] cnt_req);
        checks++;
        if (bus.retire_count !== cnt_req || bus.state !== T_FETCH) begin
            failures++;
            $display("FAIL %s end count=%0d state=%0d exp count=%0d state=1", name,
                     bus.retire_count, bus.state, cnt_req);
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0; bus.op = LW; bus.mem_ready = 1'b1;
        #12;
        checks++;
        if (bus.state !== T_RESET || obs !== '0 || bus.retire_count !== '0) begin
            failures++;
            $display("FAIL reset_hold state=%0d outs=%b cnt=%0d exp all 0", bus.state, obs,
                     bus.retire_count);
        end
        @(posedge clk);
        #1;
        checks++;
        if (bus.state !== T_RESET) begin
            failures++;
            $display("FAIL reset_edge state got=%0d exp=0", bus.state);
        end
        rst_n = 1'b1;
    endtask

    task automatic test_lw();
        push(LW, 1'b1, T_RESET);
        push_instr(LW, 0, 0);
        drain("lw", -1);
        check_after("lw", 1);
    endtask

    task automatic test_sw_stall();
        push_instr(SW, 0, 3);
        drain("sw_stall", -1);
        check_after("sw_stall", 2);
    endtask

    task automatic test_back_to_back();
        push_instr(RT, 0, 0);
        push_instr(ADDI, 0, 0);
        push_instr(BEQ, 0, 0);
        push_instr(JMP, 0, 0);
        drain("b2b", -1);
        check_after("b2b", 6);
    endtask

    task automatic test_fetch_stall();
        push_instr(ADDI, 5, 0);
        drain("fetch_stall", -1);
        check_after("fetch_stall", 7);
    endtask

    task automatic test_illegal();
        push_instr(6'h3F, 0, 0);
        drain("illegal", -1);
        check_after("illegal", 7);
    endtask

    task automatic test_reset_abort();
        push_instr(LW, 0, 4);
        drain("abort_pre", 4);
        checks++;
        if (bus.state !== T_MEMRD || bus.retire_count !== 7) begin
            failures++;
            $display("FAIL abort_pre state=%0d cnt=%0d exp state=4 cnt=7", bus.state,
                     bus.retire_count);
        end
        bus.mem_ready = 1'b1;
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if (bus.state !== T_RESET || obs !== '0 || bus.retire_count !== '0) begin
            failures++;
            $display("FAIL abort_async state=%0d outs=%b cnt=%0d exp all 0", bus.state, obs,
                     bus.retire_count);
        end
        exp_q.delete();
        exp_cnt = '0;
        repeat (2) begin
            @(negedge clk);
            checks++;
            if (bus.reg_write !== 1'b0 || bus.state !== T_RESET) begin
                failures++;
                $display("FAIL abort_hold reg_write=%b state=%0d exp 0/0", bus.reg_write,
                         bus.state);
            end
        end
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        push(JMP, 1'b1, T_RESET);
        push_instr(JMP, 0, 0);
        drain("abort_restart", -1);
        check_after("abort_restart", 1);
    endtask

    initial begin
        bus.op = '0;
        bus.mem_ready = 1'b0;
        test_reset();
        test_lw();
        test_sw_stall();
        test_back_to_back();
        test_fetch_stall();
        test_illegal();
        test_reset_abort();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/multicycle_controller.md
Name: multicycle_controller

Overview:
- Moore finite-state controller that sequences the multicycle MIPS datapath: shared instruction/data memory, single ALU, instruction register (IR), register file, and PC.
- Decodes opcode from IR[31:26] and steps through fetch, decode, execute, memory and writeback states.
- Supported instructions: R-type, lw, sw, beq, addi, j.
- Memory accesses use a request/ready handshake, so the controller stalls on slow memory.
- Counts retired instructions and flags illegal opcodes.

Parameters:
- CNT_W, 32, width of the retired-instruction counter.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- op  in  6  opcode, IR[31:26].
- mem_ready  in  1  memory completed the current request this cycle.
- mem_req  out  1  memory access request.
- i_or_d  out  1  memory address select: 0 = PC, 1 = ALUOut.
- mem_write  out  1  store strobe.
- ir_write  out  1  IR load enable.
- pc_write  out  1  unconditional PC write.
- branch  out  1  conditional PC write; datapath gates it with ALU zero.
- pc_src  out  2  next-PC select: 00 = ALU result, 01 = ALUOut, 10 = jump target.
- alu_src_a  out  1  ALU A select: 0 = PC, 1 = A register.
- alu_src_b  out  2  ALU B select: 00 = B register, 01 = constant 4, 10 = sign-extended immediate, 11 = sign-extended immediate << 2.
- alu_op  out  2  to the ALU decoder: 00 = add, 01 = subtract, 10 = funct field.
- reg_dst  out  1  destination register select: 0 = rt, 1 = rd.
- mem_to_reg  out  1  writeback data select: 0 = ALUOut, 1 = memory data.
- reg_write  out  1  register file write enable.
- instr_done  out  1  one-cycle pulse when an instruction retires.
- illegal_op  out  1  one-cycle pulse when DECODE sees an unsupported opcode.
- retire_count  out  CNT_W  retired-instruction count.
- state  out  4  current state encoding, for debug.

Behaviour:
- Reset (rst_n low, asynchronous): state = RESET (0).
  - Every output is 0 while in RESET, including retire_count.
  - After rst_n deasserts, the first clock moves RESET -> FETCH.
  - Reset asserted mid-instruction aborts the instruction immediately: no partial writeback, and the counter is cleared.
- Outputs not listed for a state are 0. Outputs are a pure function of state, plus mem_ready where noted.
- States, encodings, outputs and transitions:
  - RESET (0): all outputs 0 -> FETCH.
  - FETCH (1): mem_req=1, i_or_d=0, alu_src_a=0, alu_src_b=01, alu_op=00, pc_src=00. ir_write=pc_write=mem_ready. Stays in FETCH while mem_ready=0; -> DECODE when mem_ready=1.
  - DECODE (2): alu_src_a=0, alu_src_b=11, alu_op=00 (precomputes the branch target). Next state by op:
    - 100011 (lw) or 101011 (sw) -> MEMADR.
    - 000000 (R-type) -> EXECUTE.
    - 000100 (beq) -> BRANCH.
    - 001000 (addi) -> ADDIEX.
    - 000010 (j) -> JUMP.
    - any other opcode: illegal_op=1 -> FETCH, not counted as retired.
  - MEMADR (3): alu_src_a=1, alu_src_b=10, alu_op=00 -> MEMRD for lw, MEMWR for sw. Opcode is sampled from op; the IR is stable for the whole instruction.
  - MEMRD (4): mem_req=1, i_or_d=1. Waits for mem_ready -> MEMWB.
  - MEMWB (5): reg_write=1, reg_dst=0, mem_to_reg=1, instr_done=1 -> FETCH.
  - MEMWR (6): mem_req=1, i_or_d=1, mem_write=1; mem_write is held until mem_ready. instr_done=mem_ready. -> FETCH when mem_ready=1.
  - EXECUTE (7): alu_src_a=1, alu_src_b=00, alu_op=10 -> ALUWB.
  - ALUWB (8): reg_write=1, reg_dst=1, mem_to_reg=0, instr_done=1 -> FETCH.
  - BRANCH (9): alu_src_a=1, alu_src_b=00, alu_op=01, pc_src=01, branch=1, instr_done=1 -> FETCH.
  - ADDIEX (10): alu_src_a=1, alu_src_b=10, alu_op=00 -> ADDIWB.
  - ADDIWB (11): reg_write=1, reg_dst=0, mem_to_reg=0, instr_done=1 -> FETCH.
  - JUMP (12): pc_src=10, pc_write=1, instr_done=1 -> FETCH.
  - Encodings 13-15 are unreachable; if entered, outputs are 0 and the next state is FETCH.
- Latency, assuming mem_ready is always 1:
  - lw: 5 cycles.
  - sw, R-type, addi: 4 cycles.
  - beq, j: 3 cycles.
  - Each cycle of mem_ready=0 in a memory state adds exactly one cycle.
- retire_count increments by 1 on every clock edge where instr_done=1, and wraps modulo 2^CNT_W with no saturation.
- mem_ready is ignored outside FETCH, MEMRD and MEMWR.

Test Plan:
1. Reset then release, mem_ready=1, IR holds 0x8C080004 (lw): state sequence 0,1,2,3,4,5,1. MEMWB drives reg_write=1, mem_to_reg=1. instr_done pulses once and retire_count becomes 1.
2. sw with mem_ready low for 3 cycles in MEMWR: mem_write=1 and i_or_d=1 held for 4 cycles. instr_done pulses only on the ready cycle. Total latency 7 cycles.
3. Back-to-back R-type, addi, beq, j with mem_ready=1: latencies 4, 4, 3, 3 cycles and retire_count=4. BRANCH drives alu_op=01, pc_src=01, branch=1. JUMP drives pc_src=10, pc_write=1.
4. FETCH with mem_ready=0 for 5 cycles: ir_write=pc_write=0 and state stays 1. On the ready cycle both pulse for exactly one cycle.
5. Opcode 0x3F in DECODE: illegal_op=1 for one cycle, next state is FETCH, retire_count unchanged, reg_write and mem_write never assert.
6. rst_n pulled low asynchronously during MEMRD with retire_count=7: state immediately 0, all outputs 0, counter 0, no reg_write afterwards. After release, fetch restarts.
